// File: rtl/mem_access_unit.sv
// -----------------------------------------------------------------------------
// mem_access_unit
//
// Takes one committed, address-resolved memory operation at a time from the
// address unit's vld/rdy stream, runs the L1 data-cache read/write handshake,
// formats load data by funct_3 and broadcasts the result (or a zero completion
// token for stores) on its own common-data-bus lane tagged with the ROB index.
//
// address_data_i packing, MSB first:
//   addr[31:0] | data[31:0] | rob_dest[ROB_IDX_LEN-1:0] | funct_3[2:0] | mem_op
//   mem_op: 0 = load, 1 = store
//
// Ports:
//   clk               clock, all state changes on posedge
//   rst               asynchronous reset, active low
//   fls_i             pipeline flush, kills the current operation
//   vld_i / rdy_i     upstream element handshake (rdy_i is an output)
//   address_data_i    packed memory operation (layout above)
//   dmem_read/write   cache request strobes, held until dmem_resp
//   dmem_address      word-aligned cache address
//   dmem_wdata        store data replicated onto the addressed lanes
//   dmem_byte_enable  byte mask of the access
//   dmem_rdata        cache read data, valid with dmem_resp
//   dmem_resp         cache completes the current request
//   cdb_vld_o/rdy_i   CDB lane handshake
//   cdb_rob_dest_o    ROB tag of the broadcast result
//   cdb_data_o        formatted load data, 0 for stores
//   misalign_o        sticky flag, set when a misaligned op was accepted
// -----------------------------------------------------------------------------
module mem_access_unit #(
    parameter int ROB_IDX_LEN = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   fls_i,
    input  logic                   vld_i,
    output logic                   rdy_i,
    input  logic [ROB_IDX_LEN+67:0] address_data_i,
    output logic                   dmem_read,
    output logic                   dmem_write,
    output logic [31:0]            dmem_address,
    output logic [31:0]            dmem_wdata,
    output logic [3:0]             dmem_byte_enable,
    input  logic [31:0]            dmem_rdata,
    input  logic                   dmem_resp,
    output logic                   cdb_vld_o,
    input  logic                   cdb_rdy_i,
    output logic [ROB_IDX_LEN-1:0] cdb_rob_dest_o,
    output logic [31:0]            cdb_data_o,
    output logic                   misalign_o
);

    typedef enum logic {
        MEM_LD = 1'b0,
        MEM_ST = 1'b1
    } mem_op_e;

    typedef struct packed {
        logic [31:0]            addr;
        logic [31:0]            data;
        logic [ROB_IDX_LEN-1:0] rob_dest;
        logic [2:0]             funct_3;
        mem_op_e                mem_op;
    } address_buffer_element_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        BCAST = 2'd2,
        DRAIN = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2
    } size_e;

    // Access size from funct_3; the low two bits carry the size for both
    // signed and unsigned loads, and anything unrecognised is a word access.
    function automatic size_e decode_size(input logic [2:0] f3);
        case (f3)
            3'b000, 3'b100: decode_size = SZ_B;
            3'b001, 3'b101: decode_size = SZ_H;
            default:        decode_size = SZ_W;
        endcase
    endfunction

    function automatic logic is_misaligned(input address_buffer_element_t op);
        case (decode_size(op.funct_3))
            SZ_H:    is_misaligned = op.addr[0];
            SZ_W:    is_misaligned = (op.addr[1:0] != 2'b00);
            default: is_misaligned = 1'b0;
        endcase
    endfunction

    state_e                  state_q;
    state_e                  state_d;
    address_buffer_element_t in_op;
    address_buffer_element_t op_q;
    logic [31:0]             result_q;
    logic                    misalign_q;
    logic                    accept;
    size_e                   op_size;
    logic                    op_signed;
    logic [7:0]              rd_byte;
    logic [15:0]             rd_half;
    logic [31:0]             load_fmt;
    logic [3:0]              lane_be;
    logic [31:0]             lane_wdata;

    assign in_op  = address_buffer_element_t'(address_data_i);
    assign accept = vld_i && rdy_i && !fls_i;

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of block order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    // NOTE: every signal written in an always_comb gets a default first, so no
    // path through the case can leave it unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) state_d = REQ;
            end
            REQ: begin
                // The cache cannot be aborted: a flush without a response
                // parks in DRAIN until the outstanding request completes.
                if (dmem_resp)  state_d = fls_i ? IDLE : BCAST;
                else if (fls_i) state_d = DRAIN;
            end
            BCAST: begin
                if (fls_i || cdb_rdy_i) state_d = IDLE;
            end
            DRAIN: begin
                if (dmem_resp) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Output logic
    // -------------------------------------------------------------------------
    always_comb begin
        rdy_i            = (state_q == IDLE);
        dmem_read        = 1'b0;
        dmem_write       = 1'b0;
        cdb_vld_o        = (state_q == BCAST);
        dmem_address     = {op_q.addr[31:2], 2'b00};
        dmem_byte_enable = lane_be;
        dmem_wdata       = lane_wdata;
        cdb_rob_dest_o   = op_q.rob_dest;
        cdb_data_o       = result_q;
        misalign_o       = misalign_q;
        if (state_q == REQ || state_q == DRAIN) begin
            dmem_read  = (op_q.mem_op == MEM_LD);
            dmem_write = (op_q.mem_op == MEM_ST);
        end
    end

    // -------------------------------------------------------------------------
    // Lane steering for stores and load formatting, all from the captured op
    // so the request stays stable for as long as it is outstanding.
    // -------------------------------------------------------------------------
    always_comb begin
        op_size    = decode_size(op_q.funct_3);
        op_signed  = !op_q.funct_3[2];
        rd_byte    = dmem_rdata[{op_q.addr[1:0], 3'b000} +: 8];
        rd_half    = op_q.addr[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        lane_be    = 4'hF;
        lane_wdata = op_q.data;
        load_fmt   = dmem_rdata;
        case (op_size)
            SZ_B: begin
                lane_be    = 4'b0001 << op_q.addr[1:0];
                lane_wdata = {4{op_q.data[7:0]}};
                load_fmt   = {{24{op_signed & rd_byte[7]}}, rd_byte};
            end
            SZ_H: begin
                lane_be    = op_q.addr[1] ? 4'b1100 : 4'b0011;
                lane_wdata = {2{op_q.data[15:0]}};
                load_fmt   = {{16{op_signed & rd_half[15]}}, rd_half};
            end
            default: begin
                lane_be    = 4'hF;
                lane_wdata = op_q.data;
                load_fmt   = dmem_rdata;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Captured operation, result and sticky misalignment flag
    // -------------------------------------------------------------------------
    // NOTE: the captured op is reset as well, because its tag feeds
    // cdb_rob_dest_o directly and must read 0 out of reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_q       <= '0;
            result_q   <= '0;
            misalign_q <= 1'b0;
        end else begin
            if (accept) begin
                op_q <= in_op;
                if (is_misaligned(in_op)) misalign_q <= 1'b1;
            end
            if (state_q == REQ && dmem_resp) begin
                result_q <= (op_q.mem_op == MEM_LD) ? load_fmt : 32'h0;
            end
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// -----------------------------------------------------------------------------
// tb_mem_access_unit
//
// Drives directed and randomized memory operations through mem_access_unit,
// playing the role of the address unit, the data cache and the CDB arbiter.
// Expected cache requests and CDB results come from an arithmetic model of the
// access rules (size, lane, sign extension) kept in this file.
// -----------------------------------------------------------------------------
module tb_mem_access_unit;

    logic        clk;
    logic        rst;
    logic        fls_i;
    logic        vld_i;
    logic        rdy_i;
    logic [71:0] address_data_i;
    logic        dmem_read;
    logic        dmem_write;
    logic [31:0] dmem_address;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_byte_enable;
    logic [31:0] dmem_rdata;
    logic        dmem_resp;
    logic        cdb_vld_o;
    logic        cdb_rdy_i;
    logic [3:0]  cdb_rob_dest_o;
    logic [31:0] cdb_data_o;
    logic        misalign_o;

    int   n_vec;
    int   n_err;
    logic exp_mis;

    mem_access_unit #(.ROB_IDX_LEN(4)) dut (
        .clk              (clk),
        .rst              (rst),
        .fls_i            (fls_i),
        .vld_i            (vld_i),
        .rdy_i            (rdy_i),
        .address_data_i   (address_data_i),
        .dmem_read        (dmem_read),
        .dmem_write       (dmem_write),
        .dmem_address     (dmem_address),
        .dmem_wdata       (dmem_wdata),
        .dmem_byte_enable (dmem_byte_enable),
        .dmem_rdata       (dmem_rdata),
        .dmem_resp        (dmem_resp),
        .cdb_vld_o        (cdb_vld_o),
        .cdb_rdy_i        (cdb_rdy_i),
        .cdb_rob_dest_o   (cdb_rob_dest_o),
        .cdb_data_o       (cdb_data_o),
        .misalign_o       (misalign_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int size_of(input logic [2:0] f3);
        case (f3)
            3'd0, 3'd4: return 1;
            3'd1, 3'd5: return 2;
            default:    return 4;
        endcase
    endfunction

    function automatic int lane_of(input logic [31:0] addr, input int size);
        if (size == 1) return int'(addr % 4);
        if (size == 2) return int'(addr % 4) / 2 * 2;
        return 0;
    endfunction

    function automatic logic [3:0] model_be(input logic [31:0] addr, input logic [2:0] f3);
        int size = size_of(f3);
        int mask = (1 << size) - 1;
        return 4'(mask << lane_of(addr, size));
    endfunction

    function automatic logic [31:0] model_wdata(input logic [31:0] data, input logic [2:0] f3);
        int size = size_of(f3);
        if (size == 1) return (data & 32'hFF) * 32'h0101_0101;
        if (size == 2) return (data & 32'hFFFF) * 32'h0001_0001;
        return data;
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] addr, input logic [2:0] f3,
                                               input logic [31:0] rdata);
        int          size = size_of(f3);
        logic [31:0] mask;
        logic [31:0] v;
        if (size == 4) return rdata;
        mask = (32'd1 << (8 * size)) - 32'd1;
        v    = (rdata >> (8 * lane_of(addr, size))) & mask;
        if (f3[2] == 1'b0 && v[8*size-1]) v = v | ~mask;
        return v;
    endfunction

    function automatic logic model_mis(input logic [31:0] addr, input logic [2:0] f3);
        int size = size_of(f3);
        return (size == 2 && addr[0]) || (size == 4 && addr[1:0] != 2'b00);
    endfunction

    // ---------------- one complete operation ----------------
    // d: request cycles before resp; g: cycles cdb_rdy_i is withheld;
    // fmode: 0 none, 1 flush in first request cycle, 2 flush in BCAST;
    // idle_fls: first offer the element together with a flush.
    task automatic run_op(input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] rob, input logic [2:0] f3, input logic st,
                          input int d, input logic [31:0] rdata, input int g,
                          input int fmode, input logic idle_fls);
        logic [31:0] e_addr;
        logic [31:0] e_wdata;
        logic [31:0] e_cdb;
        logic [3:0]  e_be;
        e_addr  = addr & 32'hFFFF_FFFC;
        e_be    = model_be(addr, f3);
        e_wdata = model_wdata(data, f3);
        e_cdb   = st ? 32'h0 : model_load(addr, f3, rdata);

        check("rdy_idle", 32'(rdy_i), 32'd1);
        if (idle_fls) begin
            vld_i          = 1'b1;
            address_data_i = {addr, data, rob, f3, st};
            fls_i          = 1'b1;
            @(negedge clk);
            fls_i = 1'b0;
            check("fls_idle_rdy", 32'(rdy_i), 32'd1);
            check("fls_idle_req", 32'({dmem_read, dmem_write}), 32'd0);
        end
        vld_i          = 1'b1;
        address_data_i = {addr, data, rob, f3, st};
        @(negedge clk);
        exp_mis = exp_mis | model_mis(addr, f3);
        // Garbage offered while busy must be ignored.
        vld_i          = 1'($urandom_range(0, 1));
        address_data_i = {$urandom, $urandom, 8'($urandom)};
        fls_i          = (fmode == 1);
        for (int c = 0; c <= d; c++) begin
            check("rdy_busy", 32'(rdy_i), 32'd0);
            check("dmem_read", 32'(dmem_read), 32'(!st));
            check("dmem_write", 32'(dmem_write), 32'(st));
            check("dmem_address", dmem_address, e_addr);
            check("dmem_be", 32'(dmem_byte_enable), 32'(e_be));
            check("dmem_wdata", dmem_wdata, e_wdata);
            check("misalign", 32'(misalign_o), 32'(exp_mis));
            if (c == d) begin
                dmem_resp  = 1'b1;
                dmem_rdata = rdata;
            end else begin
                dmem_rdata = $urandom;
            end
            @(negedge clk);
            // A repeated flush while draining must change nothing.
            fls_i = (fmode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
        end
        dmem_resp = 1'b0;
        fls_i     = 1'b0;
        vld_i     = 1'b0;
        check("req_drop", 32'({dmem_read, dmem_write}), 32'd0);
        if (fmode == 1) begin
            check("fls_req_no_cdb", 32'(cdb_vld_o), 32'd0);
            check("fls_req_rdy", 32'(rdy_i), 32'd1);
            return;
        end
        cdb_rdy_i = 1'b0;
        for (int c = 0; c <= g; c++) begin
            check("cdb_vld", 32'(cdb_vld_o), 32'd1);
            check("cdb_tag", 32'(cdb_rob_dest_o), 32'(rob));
            check("cdb_data", cdb_data_o, e_cdb);
            check("rdy_bcast", 32'(rdy_i), 32'd0);
            if (fmode == 2) begin
                fls_i     = 1'b1;
                cdb_rdy_i = 1'($urandom_range(0, 1));
                vld_i     = 1'b0;
                @(negedge clk);
                fls_i     = 1'b0;
                cdb_rdy_i = 1'b0;
                check("fls_bcast_vld", 32'(cdb_vld_o), 32'd0);
                check("fls_bcast_rdy", 32'(rdy_i), 32'd1);
                return;
            end
            if (c == g) begin
                cdb_rdy_i = 1'b1;
                vld_i     = 1'b0;
            end else begin
                vld_i          = 1'b1;
                address_data_i = {$urandom, $urandom, 8'($urandom)};
            end
            @(negedge clk);
        end
        cdb_rdy_i = 1'b0;
        check("cdb_drop", 32'(cdb_vld_o), 32'd0);
        check("rdy_back", 32'(rdy_i), 32'd1);
    endtask

    // Reset applied between clock edges while a load is outstanding.
    task automatic reset_mid_req();
        vld_i          = 1'b1;
        address_data_i = {32'h0000_1000, 32'h0, 4'd5, 3'b010, 1'b0};
        @(negedge clk);
        vld_i = 1'b0;
        check("pre_rst_read", 32'(dmem_read), 32'd1);
        check("pre_rst_mis", 32'(misalign_o), 32'(exp_mis));
        #2 rst = 1'b0;
        #1;
        check("rst_read", 32'(dmem_read), 32'd0);
        check("rst_cdb_vld", 32'(cdb_vld_o), 32'd0);
        check("rst_mis", 32'(misalign_o), 32'd0);
        check("rst_rdy", 32'(rdy_i), 32'd1);
        exp_mis = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    logic [2:0] st_f3 [6];

    initial begin
        n_vec          = 0;
        n_err          = 0;
        exp_mis        = 1'b0;
        rst            = 1'b0;
        fls_i          = 1'b0;
        vld_i          = 1'b0;
        address_data_i = '0;
        dmem_rdata     = '0;
        dmem_resp      = 1'b0;
        cdb_rdy_i      = 1'b0;
        st_f3          = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd6, 3'd7};

        #12;
        check("reset_rdy", 32'(rdy_i), 32'd1);
        check("reset_read", 32'(dmem_read), 32'd0);
        check("reset_write", 32'(dmem_write), 32'd0);
        check("reset_cdb_vld", 32'(cdb_vld_o), 32'd0);
        check("reset_cdb_data", cdb_data_o, 32'd0);
        check("reset_cdb_tag", 32'(cdb_rob_dest_o), 32'd0);
        check("reset_mis", 32'(misalign_o), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Directed cases
        run_op(32'h0000_1000, 32'h0, 4'd3, 3'b010, 1'b0, 2, 32'hDEAD_BEEF, 0, 0, 1'b0); // lw
        run_op(32'h0000_2003, 32'h0, 4'd4, 3'b000, 1'b0, 0, 32'h80FF_FF7F, 1, 0, 1'b0); // lb
        run_op(32'h0000_2003, 32'h0, 4'd5, 3'b100, 1'b0, 1, 32'h80FF_FF7F, 0, 0, 1'b0); // lbu
        run_op(32'h0000_2002, 32'h0, 4'd6, 3'b101, 1'b0, 0, 32'h80FF_FF7F, 0, 0, 1'b0); // lhu
        run_op(32'h0000_3002, 32'h1234_ABCD, 4'd7, 3'b001, 1'b1, 1, 32'h5555_5555, 0, 0, 1'b0); // sh
        run_op(32'h0000_4000, 32'h0, 4'd8, 3'b010, 1'b0, 0, 32'h0BAD_F00D, 5, 0, 1'b0); // stall
        run_op(32'h0000_5004, 32'h0, 4'd9, 3'b010, 1'b0, 3, 32'h1111_2222, 0, 1, 1'b0); // drain
        run_op(32'h0000_5008, 32'h0, 4'd10, 3'b010, 1'b0, 0, 32'h3333_4444, 0, 1, 1'b1); // fls+resp
        run_op(32'h0000_6000, 32'h0, 4'd11, 3'b000, 1'b0, 0, 32'h0000_0080, 2, 2, 1'b0); // fls bcast
        run_op(32'h0000_3001, 32'hCAFE_0001, 4'd12, 3'b001, 1'b1, 0, 32'h0, 0, 0, 1'b1); // misaligned sh
        reset_mid_req();
        run_op(32'h0000_1001, 32'h0, 4'd13, 3'b010, 1'b0, 0, 32'h7654_3210, 0, 0, 1'b0); // misaligned lw
        check("mis_sticky", 32'(misalign_o), 32'd1);

        // Randomized operations
        for (int i = 0; i < 200; i++) begin
            logic        st;
            logic [2:0]  f3;
            int          fsel;
            int          fmode;
            st    = 1'($urandom_range(0, 1));
            fsel  = $urandom_range(0, 5);
            f3    = st ? st_f3[fsel] : 3'($urandom_range(0, 7));
            fmode = $urandom_range(0, 9);
            fmode = (fmode <= 6) ? 0 : (fmode <= 8) ? 1 : 2;
            run_op($urandom, $urandom, 4'($urandom), f3, st, $urandom_range(0, 3),
                   $urandom, $urandom_range(0, 3), fmode, ($urandom_range(0, 7) == 0));
        end
        check("mis_final", 32'(misalign_o), 32'(exp_mis));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
